// File: rtl/wb_pkg.sv
// Shared constants and the result entry type for the writeback arbiter.
package wb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 6;
    localparam int DEF_NUM_SRC    = 6;
    localparam int DEF_NUM_LANES  = 2;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO: registered count and head/tail pointers, synchronous flush.
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t push_entry,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_entry;
    end

    assign head  = mem[head_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, round-robin tag-distinct lane selection, registered write lanes.
// Define WB_BYPASS_EN to let an empty source's incoming result compete in the cycle it is accepted.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [NUM_SRC-1:0]              src_valid_i,
    output logic [NUM_SRC-1:0]              src_ready_o,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    src_tag_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data_i,
    output logic [NUM_LANES-1:0]            wr_en_o,
    output logic [NUM_LANES*TAG_WIDTH-1:0]  wr_tag_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] wr_data_o
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } lane_entry_t;

    lane_entry_t        in_entry   [NUM_SRC];
    lane_entry_t        head       [NUM_SRC];
    lane_entry_t        lane_entry [NUM_LANES];
    logic [NUM_SRC-1:0] empty, full, push, pop, grant, byp_grant;
    logic [NUM_LANES-1:0] lane_valid;
    logic [SRC_W-1:0]   rr_ptr, rr_next, last_src;

    // Ready is held low during reset so no source believes a transfer happened.
    assign src_ready_o = ~full & {NUM_SRC{~flush_i & rst_n}};
    assign push        = src_valid_i & src_ready_o & ~byp_grant;
    assign pop         = grant & ~empty;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign in_entry[s] = '{tag:  src_tag_i[s*TAG_WIDTH +: TAG_WIDTH],
                               data: src_data_i[s*DATA_WIDTH +: DATA_WIDTH]};

        wb_src_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (lane_entry_t)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[s]),
            .pop        (pop[s]),
            .flush      (flush_i),
            .push_entry (in_entry[s]),
            .head       (head[s]),
            .empty      (empty[s]),
            .full       (full[s])
        );
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin : arb
        int          idx;
        int          n;
        logic        cand_valid;
        logic        cand_byp;
        logic        clash;
        lane_entry_t cand;

        grant      = '0;
        byp_grant  = '0;
        lane_valid = '0;
        last_src   = rr_ptr;
        n          = 0;
        for (int l = 0; l < NUM_LANES; l++) lane_entry[l] = '0;

        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;

            cand_valid = 1'b0;
            cand_byp   = 1'b0;
            cand       = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx) begin
                    cand_valid = !empty[s];
                    cand       = head[s];
`ifdef WB_BYPASS_EN
                    if (empty[s] && src_valid_i[s] && src_ready_o[s]) begin
                        cand_valid = 1'b1;
                        cand_byp   = 1'b1;
                        cand       = in_entry[s];
                    end
`endif
                end
            end

            // A head whose tag is already on a lane this cycle waits for a later cycle.
            clash = 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (l < n && lane_entry[l].tag == cand.tag) clash = 1'b1;
            end

            if (cand_valid && !clash && n < NUM_LANES) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (s == idx) begin
                        grant[s]     = 1'b1;
                        byp_grant[s] = cand_byp;
                    end
                end
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (l == n) begin
                        lane_entry[l] = cand;
                        lane_valid[l] = 1'b1;
                    end
                end
                last_src = SRC_W'(idx);
                n        = n + 1;
            end
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (|grant) rr_next = (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            wr_en_o   <= '0;
            wr_tag_o  <= '0;
            wr_data_o <= '0;
        end else if (flush_i) begin
            rr_ptr  <= '0;
            wr_en_o <= '0;
        end else begin
            rr_ptr  <= rr_next;
            wr_en_o <= lane_valid;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_valid[l]) begin
                    wr_tag_o[l*TAG_WIDTH +: TAG_WIDTH]    <= lane_entry[l].tag;
                    wr_data_o[l*DATA_WIDTH +: DATA_WIDTH] <= lane_entry[l].data;
                end
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the functional-unit result buses and the physical register file. It buffers completed results from NUM_SRC producers in small per-source FIFOs. Each cycle it selects up to NUM_LANES results round-robin and drives them onto registered write lanes feeding the register-file cells' write ports. No two lanes ever carry the same destination tag in one cycle, so the cells' fixed write priority never silently drops a result.

## Interface
- DATA_WIDTH, 32: result data width
- TAG_WIDTH, 6: physical register tag width
- NUM_SRC, 6: producer count
- NUM_LANES, 2: register-file write lanes per cycle (1..NUM_SRC)
- FIFO_DEPTH, 2: entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline flush
- src_valid_i  in  NUM_SRC  result valid per source
- src_ready_o  out  NUM_SRC  source FIFO can accept
- src_tag_i  in  NUM_SRC*TAG_WIDTH  destination tag, source s at [s*TAG_WIDTH +: TAG_WIDTH]
- src_data_i  in  NUM_SRC*DATA_WIDTH  result data, same packing
- wr_en_o  out  NUM_LANES  lane write enable, registered
- wr_tag_o  out  NUM_LANES*TAG_WIDTH  lane destination tag, registered
- wr_data_o  out  NUM_LANES*DATA_WIDTH  lane data, registered

## Operation
- Push: source s transfers on a rising edge where src_valid_i[s] && src_ready_o[s] && !flush_i.
- src_ready_o[s] = (count[s] < FIFO_DEPTH) && !flush_i. It depends only on registered state and flush_i, and the same-cycle pop is not credited. It is 0 while rst_n is low.
- Arbitration is combinational on FIFO heads, with rr_ptr (0..NUM_SRC-1) as the start point.
  - Scan sources rr_ptr, rr_ptr+1, …, wrapping modulo NUM_SRC.
  - Grant the first NUM_LANES non-empty heads whose tag differs from every tag already granted this cycle. Lane 0 takes the first grant, lane 1 the second, and so on.
  - A skipped head (tag collision) stays at its FIFO head and retries next cycle.
- Granted heads pop on the edge. Lane registers load the granted tag/data with wr_en_o=1. Unused lanes load wr_en_o=0, and their tag/data hold previous values.
- rr_ptr update: becomes (last granted source + 1) mod NUM_SRC. It is unchanged when nothing is granted.
- Flush: on an edge with flush_i=1, all FIFO counts go to 0, pushes are dropped, rr_ptr goes to 0, and all wr_en_o go to 0.
- Reset values: wr_en_o=0, wr_tag_o=0, wr_data_o=0, rr_ptr=0, all FIFOs empty.

## Timing
- Base latency: a push accepted at edge N is eligible in cycle N+1. Its wr_en_o is high in the cycle after edge N+1, so the earliest register-file write is at edge N+2.
- Sustained throughput is min(NUM_LANES, non-empty distinct-tag sources) writes per cycle.
- With all FIFOs full and continuous valids, every source is granted at least once every ceil(NUM_SRC/NUM_LANES) cycles.
- Reset mid-operation discards all buffered results immediately. Outputs go low asynchronously.
- A flush in the same cycle as a grant cancels the grant: no write is issued and lanes are cleared.

## Configuration
- WB_BYPASS_EN defined: an empty source FIFO with src_valid_i && src_ready_o competes in arbitration that same cycle.
  - If granted, the data goes straight to a lane and is never written into the FIFO, giving latency 1 (wr_en_o high the cycle after the accepting edge).
  - Bypass candidates occupy their source's natural scan position.
- WB_BYPASS_EN undefined: only FIFO heads compete, and latency is fixed at 2.

## Structure
- Package wb_pkg holds the default DATA_WIDTH, TAG_WIDTH, NUM_SRC and NUM_LANES constants and a wb_entry_t struct {tag, data}.
- Sub-module wb_src_fifo, instantiated once per source:
  - FIFO_DEPTH entries with registered count and head/tail pointers.
  - Outputs are head entry, empty and full.
  - Inputs are push, pop and flush.
  - Asynchronous active-low reset.
- The top level contains the round-robin tag-distinct selector, rr_ptr and the lane registers.

## Test plan
- Single result: src 3 pushes tag 0x05, data 0xDEADBEEF. Lane 0 wr_en_o is high two cycles later (one with WB_BYPASS_EN) with tag 0x05 and that data; lane 1 stays idle.
- All six sources hold 1 entry with distinct tags and rr_ptr=0. Cycle 1 grants src 0,1, cycle 2 grants src 2,3, cycle 3 grants src 4,5. rr_ptr ends at 0.
- Tag collision: src 0 and src 1 both carry tag 0x10 and src 2 carries 0x11. The first grant is src 0 and src 2; src 1 writes 0x10 the next cycle.
- Backpressure: hold src_valid_i[4]=1 and stop granting it by keeping tags colliding. After FIFO_DEPTH accepts, src_ready_o[4]=0; it returns to 1 the cycle after the first pop.
- Flush with 3 sources buffered: assert flush_i for one cycle. wr_en_o is 0 the next cycle, no buffered result is ever written, and src_ready_o is all 1 afterwards.
- Drop rst_n asynchronously mid-burst: wr_en_o goes to 0 without a clock edge, and src_ready_o is 0 until release.
